// File: rtl/onchip_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 1-cycle-latency on-chip RAM.
// Supports per-requester bus lock and flags (sticky) accesses beyond the implemented depth.
module onchip_memory_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 51200
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_oor_err,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_oor_err,

  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED0  = 2'd1;
  localparam logic [1:0] ST_LOCKED1  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_grant_q;
  logic       req0, req1;
  logic       grant0, grant1;
  logic       oor0, oor1;
  logic       sel_oor, sel_write, any_grant, accept;
  logic       rvalid0_q, rvalid1_q, rzero_q;
  logic       oor_err0_q, oor_err1_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign oor0 = 32'(m0_address) >= NUM_WORDS;
  assign oor1 = 32'(m1_address) >= NUM_WORDS;

  // Grant selection and lock tracking; the lock owner keeps the port until it drops lock.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_LOCKED0: begin
        grant0 = req0;
        if (!m0_lock) state_d = ST_UNLOCKED;
      end
      ST_LOCKED1: begin
        grant1 = req1;
        if (!m1_lock) state_d = ST_UNLOCKED;
      end
      default: begin
        grant0 = req0 & (~req1 | last_grant_q);
        grant1 = req1 & ~grant0;
        if (grant0 && m0_lock)      state_d = ST_LOCKED0;
        else if (grant1 && m1_lock) state_d = ST_LOCKED1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNLOCKED;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) last_grant_q <= grant1;
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // Memory-side mux; out-of-range accesses are accepted but never reach the RAM.
  assign any_grant      = grant0 | grant1;
  assign accept         = any_grant & ~reset;
  assign sel_oor        = grant1 ? oor1 : oor0;
  assign sel_write      = grant1 ? m1_write : m0_write;
  assign mem_address    = grant1 ? m1_address : m0_address;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata : m0_writedata;
  assign mem_chipselect = accept & ~sel_oor;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rzero_q    <= 1'b0;
      oor_err0_q <= 1'b0;
      oor_err1_q <= 1'b0;
    end else begin
      rvalid0_q  <= grant0 & ~m0_write;
      rvalid1_q  <= grant1 & ~m1_write;
      rzero_q    <= sel_oor;
      oor_err0_q <= oor_err0_q | (grant0 & oor0);
      oor_err1_q <= oor_err1_q | (grant1 & oor1);
    end
  end

  // Reset suppresses a response that would otherwise land in the reset cycle.
  assign m0_readdatavalid = rvalid0_q & ~reset;
  assign m1_readdatavalid = rvalid1_q & ~reset;
  assign m0_readdata      = rzero_q ? '0 : mem_readdata;
  assign m1_readdata      = rzero_q ? '0 : mem_readdata;
  assign m0_oor_err       = oor_err0_q;
  assign m1_oor_err       = oor_err1_q;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized two-requester traffic.
module tb_onchip_memory_arbiter;

  localparam int unsigned NUM_WORDS = 51200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] addr [2];
  logic        rd [2];
  logic        wr [2];
  logic        lk [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        m0_oor_err, m1_oor_err;
  logic [15:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic        waitreq [2];
  logic [31:0] rdata [2];
  logic        rvalid [2];
  logic        oor_err [2];
  assign waitreq[0] = m0_waitrequest;
  assign waitreq[1] = m1_waitrequest;
  assign rdata[0]   = m0_readdata;
  assign rdata[1]   = m1_readdata;
  assign rvalid[0]  = m0_readdatavalid;
  assign rvalid[1]  = m1_readdatavalid;
  assign oor_err[0] = m0_oor_err;
  assign oor_err[1] = m1_oor_err;

  onchip_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_byteenable(be[0]),
    .m0_writedata(wd[0]), .m0_lock(lk[0]), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_oor_err(m0_oor_err),
    .m1_address(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_byteenable(be[1]),
    .m1_writedata(wd[1]), .m1_lock(lk[1]), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_oor_err(m1_oor_err),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with one cycle of read latency.
  logic [31:0] ram [NUM_WORDS];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken && int'(mem_address) < NUM_WORDS) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [NUM_WORDS];
  int          last_g;
  int          lock_own;
  bit          pend_v [2];
  logic [31:0] pend_d [2];
  bit          exp_oor [2];

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input int i, input bit r, input bit w, input logic [15:0] a,
                     input logic [3:0] b, input logic [31:0] d, input bit l);
    rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wd[i] = d; lk[i] = l;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) drv(i, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // One clock cycle: inputs already driven after the falling edge; returns at the next one.
  task automatic step();
    int          g;
    bit          req [2];
    bit          oor [2];
    bit          exp_cs;
    logic [31:0] t;
    #1;
    for (int i = 0; i < 2; i++) begin
      req[i] = rd[i] | wr[i];
      oor[i] = int'(addr[i]) >= NUM_WORDS;
      check("rvalid", rvalid[i], pend_v[i] && !reset);
      if (pend_v[i] && !reset) check("rdata", rdata[i], pend_d[i]);
      check("oor_err", oor_err[i], exp_oor[i]);
    end
    if (lock_own >= 0)          g = req[lock_own] ? lock_own : -1;
    else if (req[0] && req[1])  g = 1 - last_g;
    else if (req[0])            g = 0;
    else if (req[1])            g = 1;
    else                        g = -1;
    if (!reset)
      for (int i = 0; i < 2; i++) check("waitreq", waitreq[i], req[i] && g != i);
    exp_cs = !reset && g >= 0 && !oor[g];
    check("chipsel", mem_chipselect, exp_cs);
    check("memwrite", mem_write, exp_cs && wr[g]);
    if (exp_cs) begin
      check("memaddr", mem_address, addr[g]);
      if (wr[g]) begin
        check("memwdata", mem_writedata, wd[g]);
        check("membe", mem_byteenable, be[g]);
      end
    end
    @(posedge clk);
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    if (reset) begin
      last_g = 1; lock_own = -1; exp_oor[0] = 1'b0; exp_oor[1] = 1'b0;
    end else begin
      if (g >= 0) begin
        last_g = g;
        if (oor[g]) exp_oor[g] = 1'b1;
        if (wr[g]) begin
          if (!oor[g]) begin
            t = ref_mem[addr[g]];
            for (int b = 0; b < 4; b++) if (be[g][b]) t[8*b +: 8] = wd[g][8*b +: 8];
            ref_mem[addr[g]] = t;
          end
        end else begin
          pend_v[g] = 1'b1;
          pend_d[g] = oor[g] ? 32'h0 : ref_mem[addr[g]];
        end
      end
      if (lock_own < 0) begin
        if (g >= 0 && lk[g]) lock_own = g;
      end else if (!lk[lock_own] && (g == lock_own || !req[lock_own])) begin
        lock_own = -1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    last_g = 1; lock_own = -1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    exp_oor[0] = 1'b0; exp_oor[1] = 1'b0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      ram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1'b1;
    idle();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    check("clken", mem_clken, 1'b1);

    // Contention straight after reset: m0 first, then strict alternation
    for (int c = 0; c < 8; c++) begin
      drv(0, 1'b1, 1'b0, 16'(c), 4'h0, 32'h0, 1'b0);
      drv(1, 1'b1, 1'b0, 16'(c + 8), 4'h0, 32'h0, 1'b0);
      step();
    end
    idle(); step();

    // Write by m0, read back by m1
    drv(0, 1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0); step();
    idle(); drv(1, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b0); step();
    idle();
    check("t1_rdata", m1_readdata, 32'hDEADBEEF);
    step();

    // Partial byte-enable merge
    drv(0, 1'b0, 1'b1, 16'h0100, 4'hF, 32'hAAAAAAAA, 1'b0); step();
    drv(0, 1'b0, 1'b1, 16'h0100, 4'b0101, 32'h11223344, 1'b0); step();
    drv(0, 1'b1, 1'b0, 16'h0100, 4'h0, 32'h0, 1'b0); step();
    idle();
    check("t4_rdata", m0_readdata, 32'hAA22AA44);
    step();

    // m1 locked burst of five writes against continuous m0 reads
    drv(0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b0); step();
    for (int c = 0; c < 5; c++) begin
      drv(1, 1'b0, 1'b1, 16'(16'h0200 + c), 4'hF, $urandom, c < 4);
      step();
    end
    idle(); drv(0, 1'b1, 1'b0, 16'h0200, 4'h0, 32'h0, 1'b0); step();
    idle(); step();

    // Out-of-range write and read from m1
    drv(1, 1'b0, 1'b1, 16'hC800, 4'hF, 32'h12345678, 1'b0); step();
    drv(1, 1'b1, 1'b0, 16'hFFFF, 4'h0, 32'h0, 1'b0); step();
    idle();
    check("t5_rvalid", m1_readdatavalid, 1'b1);
    check("t5_rdata", m1_readdata, 32'h0);
    check("t5_oor1", m1_oor_err, 1'b1);
    check("t5_oor0", m0_oor_err, 1'b0);
    step(); step();

    // Reset right after a locked read: no response, lock dropped, m0 wins next tie
    drv(0, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1); step();
    idle(); lk[0] = 1'b1; reset = 1'b1; step();
    reset = 1'b0;
    drv(0, 1'b1, 1'b0, 16'h0011, 4'h0, 32'h0, 1'b0);
    drv(1, 1'b1, 1'b0, 16'h0012, 4'h0, 32'h0, 1'b0);
    step();
    idle(); step();

    // Randomized traffic with occasional bursts, out-of-range addresses and resets
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        int unsigned sel;
        sel = $urandom_range(0, 15);
        rd[i] = ($urandom_range(0, 2) == 0);
        wr[i] = ($urandom_range(0, 3) == 0);
        lk[i] = lk[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
        if (sel == 0)      addr[i] = 16'(NUM_WORDS + $urandom_range(0, 14335));
        else if (sel == 1) addr[i] = 16'(NUM_WORDS - 1);
        else               addr[i] = 16'($urandom_range(0, 63));
        be[i] = 4'($urandom);
        wd[i] = $urandom;
      end
      step();
    end
    reset = 1'b0;
    idle(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
